// File: rtl/clkgen_nco_multi.sv
// Multi-channel NCO clock generator: per-channel phase accumulators producing
// clock-enable pulses and soft clocks, with a config handshake and lock indicator.
module clkgen_nco_multi #(
    parameter int NUM_CH      = 5,
    parameter int ACC_W       = 24,
    parameter int CH_W        = 4,
    parameter int LOCK_CYCLES = 1024,
    parameter int CNT_W       = 11
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    input  logic              cfg_en,
    input  logic              cfg_sync,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] ce_out,
    output logic [NUM_CH-1:0] clk_out,
    output logic              locked
);

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam logic [CH_W:0]    CH_LIMIT = (CH_W+1)'(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              accept;
    logic              ch_ok;
    logic [NUM_CH-1:0] wr_sel;

    logic [ACC_W-1:0]  acc   [NUM_CH];
    logic [ACC_W-1:0]  inc   [NUM_CH];
    logic [ACC_W-1:0]  phase [NUM_CH];
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] carry_p1;
    logic [ACC_W:0]    sum_p0 [NUM_CH];

    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Ready is forced low while reset is held so no write can slip in.
    assign cfg_ready = rst_n & (state != ST_LOAD);
    assign locked    = (state == ST_RUN);
    assign accept    = cfg_valid & cfg_ready;
    assign ch_ok     = ({1'b0, cfg_ch} < CH_LIMIT);

    always_comb begin
        wr_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            wr_sel[k] = accept & ch_ok & (cfg_ch == CH_W'(k));
            sum_p0[k] = acc_add(acc[k], inc[k]);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_RUN: begin
                if (accept) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                state_nxt = ST_SETTLE;
                cnt_nxt   = '0;
            end
            ST_SETTLE: begin
                if (accept) begin
                    state_nxt = ST_LOAD;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_RUN;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_SETTLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_SETTLE;
            cnt     <= '0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            cfg_err <= accept & ~ch_ok;
        end
    end

    // ---- stage p0 -> p1: accumulate, register carry; ce_out is carry delayed one cycle
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                acc[k]   <= '0;
                inc[k]   <= '0;
                phase[k] <= '0;
            end
            en       <= '0;
            carry_p1 <= '0;
            ce_out   <= '0;
            clk_out  <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_sel[k]) begin
                    inc[k]      <= cfg_inc;
                    phase[k]    <= cfg_phase;
                    en[k]       <= cfg_en;
                    acc[k]      <= cfg_phase;
                    carry_p1[k] <= 1'b0;
                    ce_out[k]   <= 1'b0;
                    clk_out[k]  <= cfg_phase[ACC_W-1];
                end else if (en[k]) begin
                    // A pulse already owed from the previous add still goes out on restart.
                    ce_out[k] <= carry_p1[k];
                    if (accept && cfg_sync) begin
                        acc[k]      <= phase[k];
                        carry_p1[k] <= 1'b0;
                        clk_out[k]  <= phase[k][ACC_W-1];
                    end else begin
                        acc[k]      <= sum_p0[k][ACC_W-1:0];
                        carry_p1[k] <= sum_p0[k][ACC_W];
                        clk_out[k]  <= sum_p0[k][ACC_W-1];
                    end
                end else begin
                    carry_p1[k] <= 1'b0;
                    ce_out[k]   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_clkgen_nco_multi.sv
// Randomized self-checking bench for clkgen_nco_multi against a closed-form
// per-channel phase model plus an edge-count model of the lock handshake.
module tb_clkgen_nco_multi;

    localparam int NUM_CH = 5;
    localparam int ACC_W  = 16;
    localparam int CH_W   = 4;
    localparam int LOCK_C = 8;
    localparam int CNT_W  = 4;

    logic              refclk;
    logic              rst_n;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic [ACC_W-1:0]  cfg_phase;
    logic              cfg_en;
    logic              cfg_sync;
    logic              cfg_err;
    logic [NUM_CH-1:0] ce_out;
    logic [NUM_CH-1:0] clk_out;
    logic              locked;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each channel is a straight line P + n*I since its last restart.
    bit      m_en [NUM_CH];
    longint  m_p  [NUM_CH];
    longint  m_i  [NUM_CH];
    int      m_t0 [NUM_CH];
    int      m_e;
    int      m_lock_at;
    int      m_acc_edge;

    clkgen_nco_multi #(
        .NUM_CH(NUM_CH), .ACC_W(ACC_W), .CH_W(CH_W),
        .LOCK_CYCLES(LOCK_C), .CNT_W(CNT_W)
    ) dut (
        .refclk(refclk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_phase(cfg_phase),
        .cfg_en(cfg_en), .cfg_sync(cfg_sync), .cfg_err(cfg_err),
        .ce_out(ce_out), .clk_out(clk_out), .locked(locked)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @e=%0d: got %0h expected %0h", tag, m_e, got, exp);
        end
    endtask

    function automatic bit ovf(input longint p, input longint i, input int n);
        longint a, b;
        a = (p + longint'(n) * i) >> ACC_W;
        b = (p + longint'(n - 1) * i) >> ACC_W;
        return a != b;
    endfunction

    function automatic bit msb_at(input longint p, input longint i, input int n);
        longint v;
        v = (p + longint'(n) * i) % (longint'(1) << ACC_W);
        return v[ACC_W-1];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_en[k] = 0; m_p[k] = 0; m_i[k] = 0; m_t0[k] = 0;
        end
        m_e        = 0;
        m_lock_at  = LOCK_C;
        m_acc_edge = -10;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ce"},    32'(ce_out),  32'h0);
        chk({tag, "_clk"},   32'(clk_out), 32'h0);
        chk({tag, "_lock"},  32'(locked),  32'h0);
        chk({tag, "_ready"}, 32'(cfg_ready), 32'h0);
        chk({tag, "_err"},   32'(cfg_err), 32'h0);
    endtask

    // One clock: decide acceptance from the model, step the edge, compare everything.
    task automatic tick();
        bit                a;
        int                ch;
        logic [NUM_CH-1:0] ce_e, clk_e;
        bit                wr, rs;
        int                n;
        a  = cfg_valid && (m_e != m_acc_edge);
        ch = int'(cfg_ch);
        @(posedge refclk);
        #1;
        m_e++;
        for (int k = 0; k < NUM_CH; k++) begin
            wr = a && (ch == k);
            rs = wr || (a && cfg_sync && m_en[k]);
            n  = m_e - 1 - m_t0[k];
            ce_e[k] = wr ? 1'b0 : (m_en[k] && n >= 1 && ovf(m_p[k], m_i[k], n));
            if (wr) begin
                m_p[k] = longint'(cfg_phase);
                m_i[k] = longint'(cfg_inc);
                m_en[k] = cfg_en;
                m_t0[k] = m_e;
            end else if (rs) begin
                m_t0[k] = m_e;
            end
            clk_e[k] = msb_at(m_p[k], m_i[k], m_en[k] ? (m_e - m_t0[k]) : 0);
        end
        if (a) begin
            m_lock_at  = m_e + LOCK_C + 1;
            m_acc_edge = m_e;
        end
        chk("ce_out",    32'(ce_out),    32'(ce_e));
        chk("clk_out",   32'(clk_out),   32'(clk_e));
        chk("locked",    32'(locked),    32'(m_e >= m_lock_at));
        chk("cfg_ready", 32'(cfg_ready), 32'(m_e != m_acc_edge));
        chk("cfg_err",   32'(cfg_err),   32'(a && ch >= NUM_CH));
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    task automatic wr(input int ch, input int inc, input int ph, input bit en, input bit sync);
        int guard;
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_inc   = ACC_W'(inc);
        cfg_phase = ACC_W'(ph);
        cfg_en    = en;
        cfg_sync  = sync;
        guard = 0;
        while (m_e == m_acc_edge && guard < 4) begin
            tick();
            guard++;
        end
        if (guard >= 4) chk("wr_ready_timeout", 32'(cfg_ready), 32'h1);
        tick();
        cfg_valid = 1'b0;
        cfg_sync  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0;
        cfg_phase = '0; cfg_en = 1'b0; cfg_sync = 1'b0;
        model_reset();
        repeat (3) @(posedge refclk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        idle(10);
        wr(0, 'h4000, 0, 1, 0);
        idle(12);
        wr(1, 'h4000, 'h8000, 1, 0);
        idle(3);
        wr(2, 'h4000, 0, 1, 1);
        idle(12);

        // back-to-back valid: second write waits out the LOAD cycle
        cfg_valid = 1'b1; cfg_ch = 4'd3; cfg_inc = 16'h2000; cfg_phase = 16'h1000; cfg_en = 1'b1;
        tick();
        cfg_ch = 4'd4; cfg_inc = 16'hFFFF; cfg_phase = 16'h0;
        tick();
        tick();
        cfg_valid = 1'b0;
        idle(12);

        wr(7, 'h1234, 'h5678, 1, 0);
        idle(12);
        wr(15, 'h1111, 'h2222, 1, 1);
        idle(4);
        wr(3, 'h8000, 'h4000, 1, 0);
        wr(4, 0, 'hC000, 1, 0);
        idle(6);
        wr(3, 'h3000, 'h0, 0, 0);
        idle(12);

        for (int j = 0; j < 400; j++) begin
            if ($urandom_range(0, 3) == 0) begin
                cfg_valid = 1'b1;
                cfg_ch    = CH_W'($urandom_range(0, 7));
                case ($urandom_range(0, 5))
                    0: cfg_inc = 16'h0000;
                    1: cfg_inc = 16'hFFFF;
                    2: cfg_inc = 16'h8000;
                    3: cfg_inc = ACC_W'($urandom_range(1, 'h1000));
                    default: cfg_inc = ACC_W'($urandom);
                endcase
                cfg_phase = ACC_W'($urandom);
                cfg_en    = ($urandom_range(0, 7) != 0);
                cfg_sync  = ($urandom_range(0, 7) == 0);
            end else begin
                cfg_valid = 1'b0;
                cfg_sync  = 1'b0;
            end
            tick();
        end
        cfg_valid = 1'b0;
        cfg_sync  = 1'b0;
        idle(12);

        // asynchronous reset with ch0 running
        wr(0, 'h4000, 0, 1, 0);
        idle(13);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        for (int j = 0; j < 3; j++) begin
            @(posedge refclk);
            #1;
            check_all_zero("rst_hold");
        end
        model_reset();
        rst_n = 1'b1;
        idle(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clkgen_nco_multi.md
Name: clkgen_nco_multi

Overview:
- Parametrised, run-time reconfigurable multi-channel clock generator, the fabric-side successor to the fixed five-output PLL wrapper.
- Each channel is a phase accumulator (NCO) clocked from the PLL reference domain. It produces a single-cycle clock-enable pulse train and a near-50% soft clock, with programmable ratio and phase offset.
- A config handshake, a synchronous-restart command and a lock/settle indicator replace the fixed PLL parameters and the PLL `locked` output for cores that need retunable video/audio/CPU timebases.

Parameters:
- NUM_CH, 5, number of output channels (1..16)
- ACC_W, 24, accumulator/increment width in bits (8..32)
- CH_W, 4, width of cfg_ch; must satisfy 2^CH_W >= NUM_CH
- LOCK_CYCLES, 1024, settle cycles after last config write before `locked` rises (>=2)
- CNT_W, 11, settle counter width; must hold LOCK_CYCLES

Ports:
- refclk  input  1  sole clock; all logic is rising-edge
- rst_n  input  1  asynchronous, active-low reset
- cfg_valid  input  1  config write request
- cfg_ready  output  1  block can accept a write this cycle
- cfg_ch  input  CH_W  target channel
- cfg_inc  input  ACC_W  phase increment; f_out = f_refclk * cfg_inc / 2^ACC_W
- cfg_phase  input  ACC_W  accumulator preload (phase offset)
- cfg_en  input  1  channel run enable
- cfg_sync  input  1  with an accepted write: restart all enabled channels from their stored phase
- cfg_err  output  1  one-cycle pulse: a write to cfg_ch >= NUM_CH was accepted
- ce_out  output  NUM_CH  per-channel one-cycle clock-enable pulses
- clk_out  output  NUM_CH  per-channel soft clock (registered accumulator MSB)
- locked  output  1  all channels configured and stable for LOCK_CYCLES

Behaviour:
- Reset (async assert, rst_n low):
  - acc, inc, phase set to 0; en cleared.
  - ce_out=0, clk_out=0, cfg_err=0, locked=0, cfg_ready=0.
  - FSM enters SETTLE with counter=0.
- Release of reset is synchronous to refclk.
- FSM states:
  - RUN: locked=1, cfg_ready=1.
  - LOAD: one cycle, cfg_ready=0, locked=0.
  - SETTLE: cfg_ready=1, locked=0; counter increments each cycle.
- Transitions:
  - RUN/SETTLE with cfg_valid&cfg_ready -> LOAD. The write is accepted on that edge.
  - LOAD -> SETTLE, counter cleared.
  - SETTLE with counter==LOCK_CYCLES-1 and no accepted write -> RUN.
  - A write accepted in SETTLE restarts settling through LOAD.
  - After reset, with no writes, locked rises LOCK_CYCLES cycles after rst_n release.
- Write acceptance (valid channel):
  - inc[ch]<=cfg_inc, phase[ch]<=cfg_phase, en[ch]<=cfg_en, acc[ch]<=cfg_phase.
  - Other channels are untouched and keep running.
  - Maximum write rate is one per two cycles.
- cfg_sync=1 on an accepted write:
  - Additionally sets acc[k]<=phase[k] for every channel k on the same edge.
  - The written channel uses the new cfg_phase.
- Invalid channel (cfg_ch >= NUM_CH):
  - Handshake completes and the FSM still passes through LOAD/SETTLE.
  - No channel state changes, except that cfg_sync is still honoured.
  - cfg_err pulses high the cycle after acceptance.
- Accumulator, each cycle when en[k] and not being loaded:
  - {carry, acc[k]} <= acc[k] + inc[k], an (ACC_W+1)-bit unsigned sum; wrap-around is modulo 2^ACC_W.
  - ce_out[k] <= carry, so the pulse appears 1 cycle after the overflowing add.
  - clk_out[k] <= acc_next[k][ACC_W-1].
- On the load cycle of channel k: ce_out[k]<=0, clk_out[k]<=cfg_phase[ACC_W-1].
- Disabled channel or inc=0: acc holds, ce_out[k]=0, clk_out[k] holds its last value.
- inc >= 2^(ACC_W-1): clk_out aliases (undefined duty) but ce_out remains correct.
- inc = 2^ACC_W-1: ce_out is high every cycle except the wrap.
- Reset mid-operation: all channels stop immediately (async), and locked drops immediately.

Test Plan (ACC_W=16, NUM_CH=5, LOCK_CYCLES=8):
- Reset release, no writes -> locked=0 for 8 cycles, rises on cycle 8; ce_out=0, clk_out=0 throughout.
- Write ch0 inc=0x4000 phase=0 en=1 -> ce_out[0] pulses every 4 cycles, with the first pulse 5 cycles after the accept edge. clk_out[0] runs 2 low/2 high; locked low for 9 cycles then high.
- Write ch1 inc=0x4000 phase=0x8000, then write ch2 inc=0x4000 phase=0 with cfg_sync=1 -> ch1 and ch2 clk_out are 180° apart. ch1 ce pulses 2 cycles before ch2's; ch0 is restarted from phase 0.
- Two back-to-back cfg_valid cycles -> cfg_ready=0 on the cycle after the first accept, so the second write is accepted one cycle later. The settle counter restarts and locked rises 9 cycles after the second accept.
- Write cfg_ch=7 -> cfg_err pulses exactly one cycle, all ce/clk streams unchanged, locked drops and re-rises after 9 cycles.
- Assert rst_n=0 mid-stream (ch0 running) -> ce_out, clk_out and locked go to 0 without waiting for a clock edge. After release, ch0 stays disabled until rewritten.
